// File: rtl/qci_pkg.sv
// rtl/qci_pkg.sv - shared types and helpers for the QCI channel blocks
package qci_pkg;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    ARB       = 2'd0,
    SEND      = 2'd1,
    WAIT_SYNC = 2'd2
  } qarb_state_t;

  // Phases of the downstream QCI handshake block.
  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_MEASURE = 2'd1,
    HS_CORRECT = 2'd2,
    HS_SYNC    = 2'd3
  } qci_hs_state_t;

  // Index width that never collapses to zero bits.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/qci_channel_arbiter_if.sv
// rtl/qci_channel_arbiter_if.sv - requester ingress and handshake channel bundle
interface qci_channel_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       hs_data;
  logic                    hs_valid;
  logic                    hs_ready;
  logic                    hs_sync;

  // Arbiter side: accepts requester bytes, drives the handshake channel.
  modport master (
    input  req_data, req_valid, hs_ready, hs_sync,
    output req_ready, hs_data, hs_valid
  );

  // Environment side: requesters plus the handshake instance.
  modport slave (
    output req_data, req_valid, hs_ready, hs_sync,
    input  req_ready, hs_data, hs_valid
  );
endinterface

// File: rtl/qci_rr_select.sv
// rtl/qci_rr_select.sv - combinational round-robin pick starting after last_ptr
module qci_rr_select #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  last_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] cand;
  logic            found;

  // Walk last_ptr+1, last_ptr+2, ... modulo N_REQ and take the first valid one.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req_valid;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/qci_channel_arbiter.sv
// rtl/qci_channel_arbiter.sv - round-robin owner of the single QCI handshake channel
module qci_channel_arbiter
  import qci_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16,
  localparam int ID_W   = id_w(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  qci_channel_arbiter_if.master bus,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic [N_REQ-1:0]     done_pulse,
  output logic [N_REQ-1:0]     timeout_pulse,
  output logic [CNT_W-1:0]     done_cnt,
  output logic [CNT_W-1:0]     timeout_cnt
);

  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0]   ONE_HOT0   = N_REQ'(1);

  qarb_state_t         state_q, state_d;
  logic [ID_W-1:0]     last_ptr_q, last_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   hs_data_q, hs_data_d;
  logic                hs_valid_q, hs_valid_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [N_REQ-1:0]    done_pulse_q, done_pulse_d;
  logic [N_REQ-1:0]    timeout_pulse_q, timeout_pulse_d;
  logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0]    timeout_cnt_q, timeout_cnt_d;

  logic [N_REQ-1:0]    sel_grant;
  logic [ID_W-1:0]     sel_idx;
  logic                sel_any;

  qci_rr_select #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_select (
    .req_valid (bus.req_valid),
    .last_ptr  (last_ptr_q),
    .grant     (sel_grant),
    .idx       (sel_idx),
    .any       (sel_any)
  );

  // The grant is only offered while arbitrating; it is already zero when nobody asks.
  assign bus.req_ready  = (state_q == ARB) ? sel_grant : '0;
  assign bus.hs_data    = hs_data_q;
  assign bus.hs_valid   = hs_valid_q;
  assign grant_id       = grant_id_q;
  assign busy           = (state_q != ARB);
  assign done_pulse     = done_pulse_q;
  assign timeout_pulse  = timeout_pulse_q;
  assign done_cnt       = done_cnt_q;
  assign timeout_cnt    = timeout_cnt_q;

  // State register; reset leaves req 0 as the first in line and drops any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ARB;
      last_ptr_q      <= ID_W'(N_REQ - 1);
      grant_id_q      <= '0;
      hs_data_q       <= '0;
      hs_valid_q      <= 1'b0;
      timer_q         <= '0;
      done_pulse_q    <= '0;
      timeout_pulse_q <= '0;
      done_cnt_q      <= '0;
      timeout_cnt_q   <= '0;
    end else begin
      state_q         <= state_d;
      last_ptr_q      <= last_ptr_d;
      grant_id_q      <= grant_id_d;
      hs_data_q       <= hs_data_d;
      hs_valid_q      <= hs_valid_d;
      timer_q         <= timer_d;
      done_pulse_q    <= done_pulse_d;
      timeout_pulse_q <= timeout_pulse_d;
      done_cnt_q      <= done_cnt_d;
      timeout_cnt_q   <= timeout_cnt_d;
    end
  end

  // Transaction sequencing: accept, present to channel, then wait for sync or give up.
  always_comb begin
    state_d         = state_q;
    last_ptr_d      = last_ptr_q;
    grant_id_d      = grant_id_q;
    hs_data_d       = hs_data_q;
    hs_valid_d      = hs_valid_q;
    timer_d         = timer_q;
    done_pulse_d    = '0;
    timeout_pulse_d = '0;
    done_cnt_d      = done_cnt_q;
    timeout_cnt_d   = timeout_cnt_q;

    case (state_q)
      ARB: begin
        if (sel_any) begin
          hs_data_d  = bus.req_data[sel_idx*DATA_W +: DATA_W];
          grant_id_d = sel_idx;
          hs_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (bus.hs_ready) begin
          hs_valid_d = 1'b0;
          timer_d    = '0;
          state_d    = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        // Sync is checked first so that it wins over a coincident terminal count.
        if (bus.hs_sync) begin
          done_pulse_d = ONE_HOT0 << grant_id_q;
          if (done_cnt_q != '1) done_cnt_d = done_cnt_q + 1'b1;
          last_ptr_d   = grant_id_q;
          state_d      = ARB;
        end else if (timer_q == TIMER_LAST) begin
          timeout_pulse_d = ONE_HOT0 << grant_id_q;
          if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + 1'b1;
          last_ptr_d      = grant_id_q;
          state_d         = ARB;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

endmodule

// File: tb/tb_qci_channel_arbiter.sv
// tb/tb_qci_channel_arbiter.sv - directed self-checking bench for qci_channel_arbiter
module tb_qci_channel_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int CW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qci_channel_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus();

  logic [IW-1:0] grant_id;
  logic          busy;
  logic [N-1:0]  done_pulse;
  logic [N-1:0]  timeout_pulse;
  logic [CW-1:0] done_cnt;
  logic [CW-1:0] timeout_cnt;

  qci_channel_arbiter #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.master),
    .grant_id      (grant_id),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .timeout_pulse (timeout_pulse),
    .done_cnt      (done_cnt),
    .timeout_cnt   (timeout_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.hs_ready  = 1'b0;
    bus.hs_sync   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gid [6];
    int cyc [6];
    int dat [6];
    int n;
    int k;
    int pulses;
    logic got;
    logic stable;

    // Test 1: reset state and a single transaction on req 0.
    idle_inputs();
    do_reset();
    check("rst_hs_valid", bus.hs_valid, 0);
    check("rst_hs_data", bus.hs_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_timeout_cnt", timeout_cnt, 0);
    check("rst_pulses", {done_pulse, timeout_pulse}, 0);
    check("rst_req_ready", bus.req_ready, 0);

    bus.req_data[7:0] = 8'hA5;
    bus.req_valid     = 4'b0001;
    bus.hs_ready      = 1'b1;
    #1;
    check("t1_req_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    check("t1_hs_valid", bus.hs_valid, 1);
    check("t1_hs_data", bus.hs_data, 8'hA5);
    check("t1_grant_id", grant_id, 0);
    check("t1_busy", busy, 1);
    check("t1_no_ready_in_send", bus.req_ready, 0);
    tick();
    check("t1_hs_valid_drop", bus.hs_valid, 0);
    bus.hs_sync = 1'b1;
    tick();
    bus.hs_sync = 1'b0;
    check("t1_done_pulse", done_pulse, 4'b0001);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_drop", busy, 0);
    tick();
    check("t1_pulse_one_cycle", done_pulse, 0);

    // Test 2: all four requesting, immediate ready and sync.
    idle_inputs();
    do_reset();
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = DW'(8'h10 + i);
    bus.req_valid = 4'b1111;
    bus.hs_ready  = 1'b1;
    bus.hs_sync   = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.hs_valid && n < 6) begin
        gid[n] = int'(grant_id);
        dat[n] = int'(bus.hs_data);
        cyc[n] = c;
        n++;
      end
    end
    idle_inputs();
    check("t2_txn_count", n, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < n) begin
        check($sformatf("t2_order_%0d", i), gid[i], i % N);
        check($sformatf("t2_data_%0d", i), dat[i], 8'h10 + (i % N));
        if (i > 0) check($sformatf("t2_period_%0d", i), cyc[i] - cyc[i-1], 3);
      end
    end

    // Test 3: req 2 alone, channel never syncs -> timeout.
    idle_inputs();
    do_reset();
    bus.req_data[23:16] = 8'h3C;
    bus.req_valid       = 4'b0100;
    bus.hs_ready        = 1'b1;
    tick();
    bus.req_valid = '0;
    check("t3_grant_id", grant_id, 2);
    tick();
    k   = 0;
    got = 1'b0;
    while (k < TO + 8 && !got) begin
      tick();
      k++;
      if (timeout_pulse != 0 || done_pulse != 0) got = 1'b1;
    end
    check("t3_timeout_pulse", timeout_pulse, 4'b0100);
    check("t3_timeout_latency", k, TO);
    check("t3_timeout_cnt", timeout_cnt, 1);
    check("t3_done_cnt", done_cnt, 0);
    check("t3_busy", busy, 0);

    // Test 4: sync lands on the terminal-count cycle.
    idle_inputs();
    do_reset();
    bus.req_data[15:8] = 8'hC3;
    bus.req_valid      = 4'b0010;
    bus.hs_ready       = 1'b1;
    tick();
    bus.req_valid = '0;
    tick();
    repeat (TO - 1) tick();
    check("t4_no_early_pulse", {done_pulse, timeout_pulse}, 0);
    bus.hs_sync = 1'b1;
    tick();
    bus.hs_sync = 1'b0;
    check("t4_done_pulse", done_pulse, 4'b0010);
    check("t4_timeout_pulse", timeout_pulse, 0);
    check("t4_timeout_cnt", timeout_cnt, 0);
    check("t4_done_cnt", done_cnt, 1);

    // Test 5: stalled channel, then reset while waiting for sync.
    idle_inputs();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.hs_ready  = 1'b1;
    tick();
    bus.req_valid = '0;
    tick();
    bus.hs_sync = 1'b1;
    tick();
    bus.hs_sync = 1'b0;
    bus.hs_ready = 1'b0;
    bus.req_data[31:24] = 8'h5A;
    bus.req_valid       = 4'b1000;
    tick();
    bus.req_valid = '0;
    check("t5_grant_id", grant_id, 3);
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (!(bus.hs_valid && bus.hs_data == 8'h5A && timeout_pulse == 0 && busy)) stable = 1'b0;
    end
    check("t5_stall_stable", stable, 1);
    bus.hs_ready = 1'b1;
    tick();
    check("t5_in_wait_busy", busy, 1);
    check("t5_in_wait_valid", bus.hs_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done_cnt", done_cnt, 0);
    check("t5_rst_hs_valid", bus.hs_valid, 0);
    check("t5_rst_grant_id", grant_id, 0);
    bus.req_valid = 4'b1111;
    #1;
    check("t5_first_grant", bus.req_ready, 4'b0001);

    // Test 6: stray sync in ARB, then drive the done counter into saturation.
    idle_inputs();
    do_reset();
    bus.hs_sync = 1'b1;
    repeat (3) tick();
    bus.hs_sync = 1'b0;
    check("t6_stray_done_cnt", done_cnt, 0);
    check("t6_stray_timeout_cnt", timeout_cnt, 0);
    check("t6_stray_pulse", done_pulse, 0);
    bus.req_valid = 4'b0001;
    bus.hs_ready  = 1'b1;
    bus.hs_sync   = 1'b1;
    pulses = 0;
    k      = 0;
    while (pulses < (1 << CW) + 3 && k < 200) begin
      tick();
      k++;
      if (done_pulse == 4'b0001) begin
        pulses++;
        if (pulses == (1 << CW) - 1) check("t6_cnt_at_max", done_cnt, (1 << CW) - 1);
      end
    end
    bus.req_valid = '0;
    bus.hs_sync   = 1'b0;
    check("t6_completions", pulses, (1 << CW) + 3);
    check("t6_done_saturated", done_cnt, (1 << CW) - 1);
    check("t6_timeout_cnt", timeout_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
